// File: rtl/load_buffer_if.sv
// Bundles the load buffer's dispatch, CDB, ROB-check and memory signals.
// The load buffer takes the master modport; the surrounding pipeline model takes the slave modport.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

interface load_buffer_if;
   typedef struct packed {
      logic                    valid;
      logic [`ROB_TAG_LEN-1:0] tag;
      logic [`XLEN-1:0]        value;
   } cdb_data_t;

   logic                    alloc_enable;
   logic [`ROB_TAG_LEN-1:0] alloc_rob_tag;
   logic [`XLEN-1:0]        alloc_base;
   logic                    alloc_base_valid;
   logic [`ROB_TAG_LEN-1:0] alloc_base_tag;
   logic [`XLEN-1:0]        alloc_offset;
   logic                    full;
   cdb_data_t               cdb_data;
   logic [`XLEN-1:0]        load_address;
   logic [`ROB_TAG_LEN-1:0] load_rob_tag;
   logic                    pending_stores;
   logic                    mem_req;
   logic [`XLEN-1:0]        mem_addr;
   logic                    mem_rdata_valid;
   logic [`XLEN-1:0]        mem_rdata;
   logic                    cdb_req;
   logic                    cdb_grant;
   cdb_data_t               cdb_out;

   modport master (
      input  alloc_enable, alloc_rob_tag, alloc_base, alloc_base_valid, alloc_base_tag,
             alloc_offset, cdb_data, pending_stores, mem_rdata_valid, mem_rdata, cdb_grant,
      output full, load_address, load_rob_tag, mem_req, mem_addr, cdb_req, cdb_out
   );

   modport slave (
      output alloc_enable, alloc_rob_tag, alloc_base, alloc_base_valid, alloc_base_tag,
             alloc_offset, cdb_data, pending_stores, mem_rdata_valid, mem_rdata, cdb_grant,
      input  full, load_address, load_rob_tag, mem_req, mem_addr, cdb_req, cdb_out
   );
endinterface

// File: rtl/load_buffer.sv
// Load buffer: holds in-flight loads, forms addresses, clears them against older stores,
// issues one memory read at a time and broadcasts results on the CDB.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module load_buffer #(
   parameter int LB_SIZE = 4
) (
   input  logic          clock,
   input  logic          reset,
   load_buffer_if.master lb
);
   localparam int IDX_W = $clog2(LB_SIZE);
   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic [2:0] {FREE, WAIT_BASE, ADDR_RDY, WAIT_DATA, DONE} state_e;

   state_e                  state_q    [LB_SIZE];
   logic [`ROB_TAG_LEN-1:0] rob_tag_q  [LB_SIZE];
   logic [`ROB_TAG_LEN-1:0] base_tag_q [LB_SIZE];
   logic [`XLEN-1:0]        offset_q   [LB_SIZE];
   logic [`XLEN-1:0]        addr_q     [LB_SIZE];
   logic [`XLEN-1:0]        data_q     [LB_SIZE];
   logic                    mem_busy_q;
   idx_t                    query_ptr_q;

   logic               full, alloc_fire, alloc_hit, sel_found, issue, done_found, mem_return;
   idx_t               alloc_idx, sel_idx, done_idx, probe;
   logic [LB_SIZE-1:0] wake;
   logic [`XLEN-1:0]   alloc_base_eff;

   always_comb begin
      // NOTE: every signal gets a default before any branch so none can infer a latch.
      full       = 1'b1;
      alloc_idx  = '0;
      done_found = 1'b0;
      done_idx   = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      probe      = '0;
      wake       = '0;
      // Descending scan leaves the lowest matching index in place.
      for (int i = LB_SIZE - 1; i >= 0; i--) begin
         if (state_q[i] == FREE) begin
            full      = 1'b0;
            alloc_idx = idx_t'(i);
         end
         if (state_q[i] == DONE) begin
            done_found = 1'b1;
            done_idx   = idx_t'(i);
         end
         wake[i] = (state_q[i] == WAIT_BASE) && lb.cdb_data.valid &&
                   (lb.cdb_data.tag == base_tag_q[i]);
      end
      for (int k = 0; k < LB_SIZE; k++) begin
         probe = query_ptr_q + idx_t'(k);
         if (!sel_found && state_q[probe] == ADDR_RDY) begin
            sel_found = 1'b1;
            sel_idx   = probe;
         end
      end
   end

   assign alloc_fire     = lb.alloc_enable & ~full;
   assign alloc_hit      = lb.cdb_data.valid && (lb.cdb_data.tag == lb.alloc_base_tag);
   assign alloc_base_eff = lb.alloc_base_valid ? lb.alloc_base : lb.cdb_data.value;
   assign mem_return     = lb.mem_rdata_valid & mem_busy_q;
   // A returning read frees the port in the same cycle, so a new read may go out alongside it.
   assign issue          = sel_found & ~lb.pending_stores & ~(mem_busy_q & ~lb.mem_rdata_valid);

   assign lb.full         = full;
   assign lb.load_address = sel_found ? addr_q[sel_idx] : '0;
   assign lb.load_rob_tag = sel_found ? rob_tag_q[sel_idx] : '0;
   assign lb.mem_req      = issue;
   assign lb.mem_addr     = issue ? addr_q[sel_idx] : '0;
   assign lb.cdb_req      = done_found;
   assign lb.cdb_out      = {done_found & lb.cdb_grant,
                             done_found ? rob_tag_q[done_idx] : {`ROB_TAG_LEN{1'b0}},
                             done_found ? data_q[done_idx] : {`XLEN{1'b0}}};

   // NOTE: sequential state uses non-blocking assignments so every entry sees the same pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LB_SIZE; i++) state_q[i] <= FREE;
         mem_busy_q  <= 1'b0;
         query_ptr_q <= '0;
      end else begin
         for (int i = 0; i < LB_SIZE; i++) begin
            case (state_q[i])
               FREE:      if (alloc_fire && alloc_idx == idx_t'(i))
                             state_q[i] <= (lb.alloc_base_valid || alloc_hit) ? ADDR_RDY : WAIT_BASE;
               WAIT_BASE: if (wake[i]) state_q[i] <= ADDR_RDY;
               ADDR_RDY:  if (issue && sel_idx == idx_t'(i)) state_q[i] <= WAIT_DATA;
               WAIT_DATA: if (mem_return) state_q[i] <= DONE;
               DONE:      if (lb.cdb_grant && done_idx == idx_t'(i)) state_q[i] <= FREE;
               default:   state_q[i] <= FREE;
            endcase
         end
         if (issue)           mem_busy_q <= 1'b1;
         else if (mem_return) mem_busy_q <= 1'b0;
         // A blocked load hands priority to the next slot so it cannot starve the others.
         if (sel_found && !issue) query_ptr_q <= sel_idx + idx_t'(1);
      end
   end

   // NOTE: payload is left unreset; it is only read while its entry is out of FREE.
   always_ff @(posedge clock) begin
      for (int i = 0; i < LB_SIZE; i++) begin
         if (alloc_fire && alloc_idx == idx_t'(i)) begin
            rob_tag_q[i]  <= lb.alloc_rob_tag;
            base_tag_q[i] <= lb.alloc_base_tag;
            offset_q[i]   <= lb.alloc_offset;
            addr_q[i]     <= alloc_base_eff + lb.alloc_offset;
         end else if (wake[i]) begin
            addr_q[i] <= lb.cdb_data.value + offset_q[i];
         end
         if (mem_return && state_q[i] == WAIT_DATA) data_q[i] <= lb.mem_rdata;
      end
   end
endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: directed scenarios plus a randomized phase, all
// compared each cycle against a flag-per-load reference model.
module tb_load_buffer;
   logic clock = 1'b0;
   logic reset;
   load_buffer_if bus ();
   load_buffer #(.LB_SIZE(4)) dut (.clock(clock), .reset(reset), .lb(bus));

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int n_issue  = 0;

   logic        ps_all, ps_match_en;
   logic [31:0] ps_match_addr;
   assign bus.pending_stores = ps_all | (ps_match_en && (bus.load_address == ps_match_addr));

   // Reference model: one record per slot, progress kept as plain flags.
   typedef struct {
      bit          live, ready, sent, back;
      logic [4:0]  tag, src;
      logic [31:0] off, addr, data;
   } ld_t;
   ld_t m [4];
   bit  m_busy   = 1'b0;
   int  m_ptr    = 0;
   int  resp_cnt = 0;

   bit          e_full, e_ps, e_req, e_creq, e_cval;
   int          e_sel, e_done;
   logic [31:0] e_la, e_ma, e_cdat;
   logic [4:0]  e_lt, e_ctag;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: observed timeout expected event", name);
   endtask

   function automatic bit model_empty();
      for (int i = 0; i < 4; i++) if (m[i].live) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_eval();
      e_full = 1'b1;
      for (int i = 0; i < 4; i++) if (!m[i].live) e_full = 1'b0;
      e_sel = -1;
      for (int k = 0; k < 4; k++) begin
         int j = (m_ptr + k) % 4;
         if (e_sel < 0 && m[j].live && m[j].ready && !m[j].sent) e_sel = j;
      end
      e_la  = (e_sel >= 0) ? m[e_sel].addr : 32'h0;
      e_lt  = (e_sel >= 0) ? m[e_sel].tag : 5'h0;
      e_ps  = ps_all | (ps_match_en && (e_la == ps_match_addr));
      e_req = (e_sel >= 0) && !e_ps && !(m_busy && !bus.mem_rdata_valid);
      e_ma  = e_req ? e_la : 32'h0;
      e_done = -1;
      for (int i = 3; i >= 0; i--) if (m[i].live && m[i].back) e_done = i;
      e_creq = (e_done >= 0);
      e_cval = e_creq && bus.cdb_grant;
      e_ctag = e_creq ? m[e_done].tag : 5'h0;
      e_cdat = e_creq ? m[e_done].data : 32'h0;
   endtask

   task automatic model_commit();
      int slot = -1;
      if (reset) begin
         for (int i = 0; i < 4; i++) m[i].live = 1'b0;
         m_busy = 1'b0; m_ptr = 0; resp_cnt = 0;
         return;
      end
      if (bus.alloc_enable && !e_full)
         for (int i = 3; i >= 0; i--) if (!m[i].live) slot = i;
      if (bus.mem_rdata_valid && m_busy) begin
         for (int i = 0; i < 4; i++)
            if (m[i].live && m[i].sent && !m[i].back) begin
               m[i].back = 1'b1; m[i].data = bus.mem_rdata;
            end
         m_busy = 1'b0;
      end
      if (resp_cnt > 0) resp_cnt--;
      if (e_req) begin
         m[e_sel].sent = 1'b1; m_busy = 1'b1; n_issue++;
         resp_cnt = $urandom_range(0, 2);
      end else if (e_sel >= 0) begin
         m_ptr = (e_sel + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
         if (m[i].live && !m[i].ready && bus.cdb_data.valid && bus.cdb_data.tag == m[i].src) begin
            m[i].ready = 1'b1; m[i].addr = bus.cdb_data.value + m[i].off;
         end
      if (bus.cdb_grant && e_done >= 0) m[e_done].live = 1'b0;
      if (slot >= 0) begin
         bit hit = bus.cdb_data.valid && (bus.cdb_data.tag == bus.alloc_base_tag);
         m[slot] = '{live: 1'b1, ready: (bus.alloc_base_valid || hit), sent: 1'b0, back: 1'b0,
                     tag: bus.alloc_rob_tag, src: bus.alloc_base_tag, off: bus.alloc_offset,
                     addr: (bus.alloc_base_valid ? bus.alloc_base : bus.cdb_data.value) + bus.alloc_offset,
                     data: 32'h0};
      end
   endtask

   task automatic idle();
      reset = 1'b0;
      bus.alloc_enable = 1'b0; bus.alloc_rob_tag = '0; bus.alloc_base = '0;
      bus.alloc_base_valid = 1'b0; bus.alloc_base_tag = '0; bus.alloc_offset = '0;
      bus.cdb_data = '0; bus.mem_rdata_valid = 1'b0; bus.mem_rdata = '0; bus.cdb_grant = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] tag, input logic [31:0] base, input bit bv,
                        input logic [4:0] btag, input logic [31:0] off);
      bus.alloc_enable = 1'b1; bus.alloc_rob_tag = tag; bus.alloc_base = base;
      bus.alloc_base_valid = bv; bus.alloc_base_tag = btag; bus.alloc_offset = off;
   endtask

   task automatic auto_mem();
      bus.mem_rdata_valid = m_busy && (resp_cnt == 0);
      bus.mem_rdata = $urandom;
   endtask

   task automatic settle();
      #1;
      model_eval();
      check("full", 64'(bus.full), 64'(e_full));
      check("load_address", 64'(bus.load_address), 64'(e_la));
      check("load_rob_tag", 64'(bus.load_rob_tag), 64'(e_lt));
      check("mem_req", 64'(bus.mem_req), 64'(e_req));
      if (e_req) check("mem_addr", 64'(bus.mem_addr), 64'(e_ma));
      check("cdb_req", 64'(bus.cdb_req), 64'(e_creq));
      check("cdb_valid", 64'(bus.cdb_out.valid), 64'(e_cval));
      if (e_creq) begin
         check("cdb_tag", 64'(bus.cdb_out.tag), 64'(e_ctag));
         check("cdb_value", 64'(bus.cdb_out.value), 64'(e_cdat));
      end
   endtask

   task automatic advance();
      @(posedge clock);
      model_commit();
      #1;
      idle();
   endtask

   task automatic drain(input int max_cycles);
      for (int k = 0; k < max_cycles && !model_empty(); k++) begin
         for (int i = 3; i >= 0; i--)
            if (m[i].live && !m[i].ready) bus.cdb_data = {1'b1, m[i].src, 32'($urandom)};
         auto_mem(); bus.cdb_grant = 1'b1;
         settle(); advance();
      end
      if (!model_empty()) fail_now("drain");
   endtask

   task automatic wait_issue(input string name, input logic [31:0] addr, input int max_cycles);
      bit seen = 1'b0;
      for (int k = 0; k < max_cycles && !seen; k++) begin
         auto_mem(); bus.cdb_grant = 1'b1;
         settle();
         if (e_req) begin
            seen = 1'b1;
            check(name, 64'(bus.mem_addr), 64'(addr));
         end
         advance();
      end
      if (!seen) fail_now(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      ps_all = 1'b0; ps_match_en = 1'b0; ps_match_addr = '0;
      idle();
      reset = 1'b1;
      @(posedge clock); model_commit(); #1;

      // Reset values
      reset = 1'b1;
      settle();
      check("rst_full", 64'(bus.full), 64'(0));
      check("rst_load_address", 64'(bus.load_address), 64'(0));
      check("rst_mem_req", 64'(bus.mem_req), 64'(0));
      check("rst_cdb_valid", 64'(bus.cdb_out.valid), 64'(0));
      advance();

      // Basic load: issue same cycle as query, return, broadcast
      alloc(5'd2, 32'h100, 1'b1, 5'd0, 32'h8); settle(); advance();
      settle();
      check("t1_load_address", 64'(bus.load_address), 64'(32'h108));
      check("t1_load_rob_tag", 64'(bus.load_rob_tag), 64'(2));
      check("t1_mem_req", 64'(bus.mem_req), 64'(1));
      check("t1_mem_addr", 64'(bus.mem_addr), 64'(32'h108));
      advance();
      bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hDEAD; settle(); advance();
      settle();
      check("t1_cdb_req", 64'(bus.cdb_req), 64'(1));
      bus.cdb_grant = 1'b1; settle();
      check("t1_cdb_out", 64'(bus.cdb_out), 64'({1'b1, 5'd2, 32'hDEAD}));
      advance();
      settle();
      check("t1_full_after", 64'(bus.full), 64'(0));
      advance();

      // Base wakeup from the CDB
      alloc(5'd3, 32'h0, 1'b0, 5'd1, 32'h4); settle(); advance();
      for (int c = 0; c < 2; c++) begin
         settle(); check("t2_no_req", 64'(bus.mem_req), 64'(0)); advance();
      end
      bus.cdb_data = {1'b1, 5'd1, 32'h20}; settle();
      check("t2_no_req_wake", 64'(bus.mem_req), 64'(0));
      advance();
      settle();
      check("t2_load_address", 64'(bus.load_address), 64'(32'h24));
      check("t2_mem_req", 64'(bus.mem_req), 64'(1));
      advance();
      drain(20);

      // Held off by pending stores
      ps_all = 1'b1;
      alloc(5'd4, 32'h10, 1'b1, 5'd0, 32'h0); settle(); advance();
      for (int c = 0; c < 3; c++) begin
         settle();
         check("t3_blocked", 64'(bus.mem_req), 64'(0));
         check("t3_addr", 64'(bus.load_address), 64'(32'h10));
         advance();
      end
      ps_all = 1'b0; settle();
      check("t3_release", 64'(bus.mem_addr), 64'({31'h0, bus.mem_req} * 32'h10 + 32'h0));
      check("t3_release_req", 64'(bus.mem_req), 64'(1));
      advance();
      drain(20);

      // Query rotation past a blocked load
      ps_match_en = 1'b1; ps_match_addr = 32'h10;
      alloc(5'd0, 32'h10, 1'b1, 5'd0, 32'h0); settle(); advance();
      alloc(5'd1, 32'h20, 1'b1, 5'd0, 32'h0); settle(); advance();
      wait_issue("t4_first", 32'h20, 6);
      ps_match_en = 1'b0;
      wait_issue("t4_second", 32'h10, 8);
      drain(20);

      // Full buffer ignores a fifth allocation
      ps_all = 1'b1; n0 = n_issue;
      for (int i = 0; i < 4; i++) begin
         alloc(5'(8 + i), 32'h100 + 32'(i) * 32'h40, 1'b1, 5'd0, 32'h0); settle(); advance();
      end
      alloc(5'd12, 32'h999, 1'b1, 5'd0, 32'h0); settle();
      check("t5_full", 64'(bus.full), 64'(1));
      advance();
      ps_all = 1'b0; settle(); advance();
      bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h5A5A; settle(); advance();
      settle();
      check("t5_cdb_req", 64'(bus.cdb_req), 64'(1));
      check("t5_still_full", 64'(bus.full), 64'(1));
      bus.cdb_grant = 1'b1; settle(); advance();
      settle();
      check("t5_freed", 64'(bus.full), 64'(0));
      advance();
      drain(40);
      check("t5_issue_count", 64'(n_issue - n0), 64'(4));

      // Address wrap, then reset with a read outstanding
      alloc(5'd5, 32'hFFFF_FFFC, 1'b1, 5'd0, 32'h8); settle(); advance();
      settle();
      check("t6_wrap_addr", 64'(bus.load_address), 64'(32'h4));
      check("t6_wrap_mem_addr", 64'(bus.mem_addr), 64'(32'h4));
      advance();
      reset = 1'b1; settle(); advance();
      settle();
      check("t6_rst_load_address", 64'(bus.load_address), 64'(0));
      check("t6_rst_load_rob_tag", 64'(bus.load_rob_tag), 64'(0));
      check("t6_rst_mem_req", 64'(bus.mem_req), 64'(0));
      check("t6_rst_cdb_req", 64'(bus.cdb_req), 64'(0));
      advance();
      bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hBEEF; settle(); advance();
      for (int c = 0; c < 2; c++) begin
         settle(); check("t6_stale_return", 64'(bus.cdb_req), 64'(0)); advance();
      end

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 1) == 1)
            alloc(5'($urandom), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         if ($urandom_range(0, 9) < 4) bus.cdb_data = {1'b1, 5'($urandom_range(0, 7)), 32'($urandom)};
         auto_mem();
         bus.cdb_grant = 1'($urandom_range(0, 1));
         ps_all = ($urandom_range(0, 9) < 3);
         reset = ($urandom_range(0, 99) == 0);
         settle(); advance();
      end
      ps_all = 1'b0;
      drain(80);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/load_buffer.md
Name: load_buffer

Overview:
- Holds in-flight loads between dispatch and writeback; it is the requester side of the ROB pending-store check.
- Computes the effective address once the base register is available, from the dispatch value or a CDB wakeup.
- Presents load_address/load_rob_tag to the ROB and waits until pending_stores is low.
- Issues one memory read at a time, then arbitrates for the CDB to broadcast the loaded value under the load's ROB tag.

Parameters:
LB_SIZE, 4, number of load buffer entries (power of 2, ≥2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
alloc_enable  input  1  dispatch a new load this cycle
alloc_rob_tag  input  `ROB_TAG_LEN  ROB slot of the load
alloc_base  input  `XLEN  base register value
alloc_base_valid  input  1  alloc_base is valid
alloc_base_tag  input  `ROB_TAG_LEN  producer tag when base is not valid
alloc_offset  input  `XLEN  sign-extended immediate
full  output  1  no free entry
cdb_data  input  CDB_DATA  CDB snoop {valid, tag, value}
load_address  output  `XLEN  address presented to the ROB check
load_rob_tag  output  `ROB_TAG_LEN  tag presented to the ROB check
pending_stores  input  1  ROB reply, combinational, same cycle
mem_req  output  1  read request, one-cycle pulse
mem_addr  output  `XLEN  read address
mem_rdata_valid  input  1  read data return
mem_rdata  input  `XLEN  read data
cdb_req  output  1  request for the CDB
cdb_grant  input  1  CDB granted this cycle
cdb_out  output  CDB_DATA  broadcast {valid = cdb_req & cdb_grant, tag, value}

Behaviour:
- Per-entry states: FREE, WAIT_BASE, ADDR_RDY, WAIT_DATA, DONE.
- Entry fields: rob_tag, base/base_tag, offset, addr, data.
- Reset (synchronous, active-high; aborts any operation in flight):
  - all entries go to FREE; mem_busy=0; query_ptr=0.
  - outputs: full=0, mem_req=0, cdb_req=0, cdb_out.valid=0, load_address=0, load_rob_tag=0, mem_addr=0.
  - a mem_rdata_valid pulse arriving after reset is ignored.
- Allocation:
  - When alloc_enable && !full, the lowest-index FREE entry is written at posedge.
  - It enters ADDR_RDY if alloc_base_valid; otherwise it enters WAIT_BASE.
  - If cdb_data.valid and cdb_data.tag==alloc_base_tag in the same cycle, the CDB value is captured and the entry enters ADDR_RDY.
  - Allocation while full is ignored; no state changes.
- full is computed from registered state only; an entry freed in a cycle does not accept an allocation that same cycle.
- Wakeup: a WAIT_BASE entry whose base_tag matches a valid cdb_data.tag captures the value and moves to ADDR_RDY next cycle.
- Address: addr = base + offset, modulo 2^XLEN (wraps, no exception). It is computed at the transition into ADDR_RDY.
- Query:
  - Each cycle, the first ADDR_RDY entry found scanning circularly from query_ptr drives load_address/load_rob_tag. If none exists, both outputs are 0.
  - If pending_stores=0 and !mem_busy: mem_req=1 and mem_addr=addr that cycle; the entry goes to WAIT_DATA; mem_busy=1.
  - If pending_stores=1 or mem_busy: the entry stays in ADDR_RDY and query_ptr advances to (selected+1) mod LB_SIZE, so blocked loads cannot starve others.
  - Minimum latency from ADDR_RDY entry to mem_req is 0 cycles (same cycle as the query).
- Memory:
  - Only one read is outstanding at a time.
  - mem_rdata_valid moves the WAIT_DATA entry to DONE, latches data, and clears mem_busy.
  - Response latency is ≥1 cycle after mem_req.
  - mem_req may fire in the same cycle as mem_rdata_valid, since mem_busy is cleared combinationally by the return.
- Writeback:
  - cdb_req=1 whenever any entry is DONE; the lowest-index DONE entry drives cdb_out.tag/value.
  - On cdb_grant that entry goes to FREE at posedge.
  - cdb_out.valid=0 without a grant.
- Simultaneous events: a free from DONE, a capture from the CDB, a transition to WAIT_DATA and an allocation into a different entry all occur in one cycle without conflict.

Test Plan:
- Reset, then allocate {tag 2, base 0x100 valid, offset 0x8}, pending_stores=0 → same cycle after allocation: load_address=0x108, load_rob_tag=2, mem_req=1, mem_addr=0x108. Next cycle mem_rdata_valid with 0xDEAD → cdb_req=1; with cdb_grant, cdb_out={1,2,0xDEAD}; entry freed and full=0.
- Allocate {tag 3, base tag 1 invalid, offset 4}; drive cdb_data={1,1,0x20} 2 cycles later → address 0x24 is presented the following cycle; no mem_req before the wakeup.
- pending_stores held at 1 for 3 cycles with one load at 0x10 → mem_req stays 0; the load issues in the cycle pending_stores drops.
- Two ADDR_RDY loads (0x10 tag 0, 0x20 tag 1); pending_stores=1 only for 0x10 → the query rotates and 0x20 issues first; 0x10 issues after its block clears. mem_req is never high while mem_busy.
- Allocate 4 loads → full=1; a 5th allocation is ignored (entry contents unchanged). After one CDB grant, full=0 next cycle.
- Assert reset while one load is in WAIT_DATA → all outputs 0 next cycle; a later mem_rdata_valid produces no cdb_req. Also check base 0xFFFFFFFC + offset 8 → address 0x4 (wrap).
